board_controller: RTL
=====================

BOARD_CONTROLLER -- requirements
Module: board_controller

Interface
REQ-001 The block SHALL have parameter CHECK_WAIT, default 2: cycles waited after a placement before game_status is sampled (legal range 1..7).
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- new_game  in  1  synchronous clear request, sampled each cycle.
- move_valid  in  1  the requesting player has a drop pending.
- move_col  in  2  target column, 0..3.
- game_status  in  2  winner-detector result: 00 playing, 01 P1 wins, 10 P2 wins, 11 tie.
- move_ready  out  1  high only in WAIT_MOVE.
- move_reject  out  1  one-cycle pulse when the target column is full.
- current_player  out  1  0 = P1 to move, 1 = P2 to move.
- game_board  out  16  occupancy; bit set = cell filled.
- player_cells  out  16  owner per cell; 1 = P2, 0 = P1; meaningful only where game_board is 1.
- game_over  out  1  high in GAME_OVER.

Function
REQ-003 Board mapping SHALL be: row 1 (top) = bits 15..12, row 4 (bottom) = bits 3..0; column c = bits {12+c, 8+c, 4+c, c}.
REQ-004 Gravity SHALL apply: the k-th piece in column c (k = 0..3) occupies bit 4*k + c.
REQ-005 Per-column height counters SHALL be 3 bits wide, range 0..4, and SHALL never wrap.
REQ-006 The FSM SHALL have states WAIT_MOVE, PLACE, CHECK and GAME_OVER.
REQ-007 In WAIT_MOVE, move_valid=1 with height[move_col]<4 SHALL register move_col and go to PLACE.
REQ-008 In WAIT_MOVE, move_valid=1 with height[move_col]=4 SHALL pulse move_reject for 1 cycle, stay in WAIT_MOVE, and leave the board and current_player unchanged.
REQ-009 In PLACE, on 1 clock: set game_board bit, set player_cells bit := current_player, increment height, go to CHECK.
REQ-010 In CHECK, a counter SHALL count CHECK_WAIT cycles, then game_status is sampled.
REQ-011 After the CHECK sample: if game_status is nonzero, go to GAME_OVER; otherwise toggle current_player and go to WAIT_MOVE.
REQ-012 Total latency from move acceptance to move_ready re-asserting SHALL be CHECK_WAIT+2 cycles.
REQ-013 move_valid SHALL be ignored outside WAIT_MOVE; no queuing.
REQ-014 A full board that game_status reports as 00 SHALL be treated as tie and go to GAME_OVER (guards against detector misses).
REQ-015 GAME_OVER SHALL hold the board, player_cells and current_player frozen until new_game or reset.
REQ-016 new_game=1 in any state SHALL, on the next edge, clear the board, player_cells and heights, set current_player:=0, and go to WAIT_MOVE.
REQ-017 new_game SHALL take priority over a simultaneous move_valid and over the CHECK sample.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 While reset=0, the block SHALL asynchronously force: state=WAIT_MOVE, game_board=0, player_cells=0, heights=0, current_player=0, move_reject=0, game_over=0, CHECK counter=0.
REQ-020 Reset asserted mid-CHECK or mid-PLACE SHALL discard the in-flight move entirely.
REQ-021 move_ready SHALL go high on the first edge after reset deassertion.

Structure
REQ-022 Shared package connect4_pkg SHALL hold the game_status encodings, the FSM state encoding, and the constants ROWS=4 and COLS=4.
REQ-023 Sub-module col_height (one per column, 4 instances) SHALL hold the 3-bit counter with inc/clear/full, and it SHALL never exceed 4.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Drop col 0 four times, detector model running, no win: game_board bits 0,4,8,12 set; player_cells bits 0,4,8,12 = 0,1,0,1; fifth drop into col 0 -> move_reject pulse, board unchanged, current_player unchanged.
- P1 plays cols 0,1,2,3 and P2 plays cols 0,1,2 interleaved; detector returns 01 -> game_over=1, game_board=16'h007F, player_cells bits 0..3=0.
- move_valid held high through CHECK -> exactly one placement per WAIT_MOVE visit; measured accept-to-ready latency = 4 cycles at CHECK_WAIT=2.
- new_game and move_valid asserted in the same WAIT_MOVE cycle -> board 0, current_player 0, no placement.
- reset pulled low during CHECK after the 3rd move -> all outputs zero immediately, move_ready=1 on the first edge after release.
- 16 legal moves filled with no win while the detector is stuck at 00 -> GAME_OVER reached via the full-board rule, game_board=16'hFFFF.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared constants for the 4x4 drop-piece board controller.
// Status codes, FSM encodings and board geometry.
package connect4_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  localparam logic [1:0] GS_PLAYING = 2'b00;
  localparam logic [1:0] GS_P1_WIN  = 2'b01;
  localparam logic [1:0] GS_P2_WIN  = 2'b10;
  localparam logic [1:0] GS_TIE     = 2'b11;

  localparam logic [1:0] S_WAIT_MOVE = 2'd0;
  localparam logic [1:0] S_PLACE     = 2'd1;
  localparam logic [1:0] S_CHECK     = 2'd2;
  localparam logic [1:0] S_GAME_OVER = 2'd3;

endpackage

// File: rtl/board_controller_if.sv
// Move request handshake between a player source and the controller.
// The master side drives the move; the slave side accepts or rejects it.
interface board_controller_if;

  logic       move_valid;
  logic [1:0] move_col;
  logic       move_ready;
  logic       move_reject;

  modport master (
    output move_valid,
    output move_col,
    input  move_ready,
    input  move_reject
  );

  modport slave (
    input  move_valid,
    input  move_col,
    output move_ready,
    output move_reject
  );

endinterface

// File: rtl/board_controller_col_height.sv
// Per-column fill counter, saturating at ROWS.
// Clear wins over increment.
module col_height
  import connect4_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [2:0] height,
  output logic       full
);

  assign full = (height >= 3'(ROWS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      height <= 3'd0;
    end else if (clr) begin
      height <= 3'd0;
    end else if (inc && !full) begin
      height <= height + 3'd1;
    end
  end

endmodule

// File: rtl/board_controller.sv
// Turn sequencing and board state for a 4x4 drop-piece game.
// Places one piece per accepted move, then waits for the detector.
module board_controller
  import connect4_pkg::*;
#(
  parameter int CHECK_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic [1:0]  game_status,
  board_controller_if.slave mv,
  output logic        current_player,
  output logic [15:0] game_board,
  output logic [15:0] player_cells,
  output logic        game_over
);

  logic [1:0]      state;
  logic [1:0]      state_nx;
  logic [1:0]      col_q;
  logic [2:0]      cnt;
  logic            ready_q;
  logic            reject_q;
  logic [2:0]      h [COLS];
  logic [COLS-1:0] full;
  logic [COLS-1:0] inc;
  logic [2:0]      h_sel;
  logic [4:0]      pos;
  logic [15:0]     bit_m;
  logic            accept;
  logic            rej;
  logic            check_done;
  logic            end_game;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    col_height u_height (
      .clk    (clk),
      .reset  (reset),
      .inc    (inc[c]),
      .clr    (new_game),
      .height (h[c]),
      .full   (full[c])
    );
  end

  assign mv.move_ready  = ready_q;
  assign mv.move_reject = reject_q;

  always_comb begin
    accept     = (state == S_WAIT_MOVE) && mv.move_valid
               && !full[mv.move_col];
    rej        = (state == S_WAIT_MOVE) && mv.move_valid
               && full[mv.move_col];
    check_done = (state == S_CHECK)
               && (cnt == 3'(CHECK_WAIT - 1));
    // A full board ends the game even if the detector says playing
    end_game   = (game_status != GS_PLAYING) || (&game_board);
    h_sel      = h[col_q];
    pos        = {h_sel, 2'b00} + {3'b000, col_q};
    bit_m      = 16'h0001 << pos;
    inc        = '0;
    if (state == S_PLACE && !new_game) begin
      inc = 4'b0001 << col_q;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_WAIT_MOVE: if (accept) state_nx = S_PLACE;
      S_PLACE:     state_nx = S_CHECK;
      S_CHECK: begin
        if (check_done) begin
          state_nx = end_game ? S_GAME_OVER : S_WAIT_MOVE;
        end
      end
      default:     state_nx = state;
    endcase
    if (new_game) state_nx = S_WAIT_MOVE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_WAIT_MOVE;
      col_q          <= 2'd0;
      cnt            <= 3'd0;
      ready_q        <= 1'b0;
      reject_q       <= 1'b0;
      current_player <= 1'b0;
      game_board     <= 16'h0000;
      player_cells   <= 16'h0000;
      game_over      <= 1'b0;
    end else begin
      state     <= state_nx;
      ready_q   <= (state_nx == S_WAIT_MOVE);
      game_over <= (state_nx == S_GAME_OVER);
      reject_q  <= rej && !new_game;
      if (new_game) begin
        cnt            <= 3'd0;
        current_player <= 1'b0;
        game_board     <= 16'h0000;
        player_cells   <= 16'h0000;
      end else begin
        case (state)
          S_WAIT_MOVE: if (accept) col_q <= mv.move_col;
          S_PLACE: begin
            game_board <= game_board | bit_m;
            player_cells <= current_player
                          ? (player_cells | bit_m)
                          : (player_cells & ~bit_m);
            cnt <= 3'd0;
          end
          S_CHECK: begin
            if (check_done) begin
              cnt <= 3'd0;
              if (!end_game) current_player <= ~current_player;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          default: cnt <= 3'd0;
        endcase
      end
    end
  end

endmodule
